// File: rtl/cache_mem_responder.sv
// Memory-side responder: serves single/block reads through a read buffer and absorbs
// writes through a write buffer. Define RESP_PERF_CNT_EN to build request counters.
`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 12
`endif
`ifndef BW_BLOCK
`define BW_BLOCK 4
`endif

module cache_mem_responder #(
  parameter int unsigned BW_ADDR     = `BW_WORD_ADDR,
  parameter int unsigned BLOCK_WORDS = 2**`BW_BLOCK,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic               req_block_i,
  input  logic               rw_i,
  input  logic [BW_ADDR-1:0] add_i,
  input  logic               write_i,
  input  logic [31:0]        data_i,
  input  logic               read_i,
  output logic               ready_req_o,
  output logic               ready_write_o,
  output logic               ready_read_o,
  output logic [31:0]        data_o,
  output logic [BW_ADDR-1:0] mem_add_o,
  output logic               mem_wren_o,
  output logic [31:0]        mem_data_o,
  input  logic [31:0]        mem_data_i,
  output logic [31:0]        cnt_rd_o,
  output logic [31:0]        cnt_wr_o
);

  localparam int unsigned CW = $clog2(BLOCK_WORDS) + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = PW + 1;

  typedef enum logic [1:0] {IDLE, RD_FETCH, RD_DRAIN, WR} state_t;

  state_t             state_q, state_d;
  logic [BW_ADDR-1:0] base_q;
  logic [CW-1:0]      n_q;
  logic [CW-1:0]      xfer_cnt_q;   // reads issued / words written to memory
  logic [CW-1:0]      fill_cnt_q;   // words pushed into the active buffer
  logic               inflight_q;
  logic               accept, issue, wr_drain, room;

  logic [31:0]   rmem [FIFO_DEPTH];
  logic [PW-1:0] r_wp_q, r_rp_q;
  logic [FW-1:0] r_cnt_q, r_cnt_d;
  logic          r_push, r_pop;

  logic [31:0]   wmem [FIFO_DEPTH];
  logic [PW-1:0] w_wp_q, w_rp_q;
  logic [FW-1:0] w_cnt_q;
  logic          w_push, w_pop;
  logic [CW-1:0] fill_cnt_nxt;

  assign accept       = (state_q == IDLE) && req_i;
  assign r_push       = inflight_q;
  assign r_pop        = read_i && (r_cnt_q != '0);
  assign r_cnt_d      = r_cnt_q + FW'(r_push) - FW'(r_pop);
  assign room         = (r_cnt_q + FW'(inflight_q)) < FW'(FIFO_DEPTH);
  assign fill_cnt_nxt = fill_cnt_q + CW'(inflight_q);
  assign w_push       = write_i && ready_write_o;
  assign w_pop        = wr_drain;

  assign ready_req_o   = (state_q == IDLE);
  assign ready_write_o = (state_q == WR) && (w_cnt_q != FW'(FIFO_DEPTH)) && (fill_cnt_q < n_q);
  assign ready_read_o  = (r_cnt_q != '0);
  assign data_o        = ready_read_o ? rmem[r_rp_q] : '0;
  assign mem_add_o     = (issue || wr_drain) ? base_q + BW_ADDR'(xfer_cnt_q) : '0;
  assign mem_wren_o    = wr_drain;
  assign mem_data_o    = wr_drain ? wmem[w_rp_q] : '0;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state plus per-cycle memory issue/drain strobes
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    wr_drain = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) state_d = rw_i ? WR : RD_FETCH;
      end
      RD_FETCH: begin
        if ((xfer_cnt_q < n_q) && room) begin
          issue = 1'b1;
          if (xfer_cnt_q + CW'(1) == n_q) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        // Look ahead at this cycle's push/pop so the last pop returns straight to IDLE
        if ((fill_cnt_nxt == n_q) && (r_cnt_d == '0)) state_d = IDLE;
      end
      WR: begin
        if (w_cnt_q != '0) begin
          wr_drain = 1'b1;
          if (xfer_cnt_q + CW'(1) == n_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      base_q     <= '0;
      n_q        <= '0;
      xfer_cnt_q <= '0;
      fill_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (accept) begin
        base_q     <= req_block_i ? (add_i & ~BW_ADDR'(BLOCK_WORDS - 1)) : add_i;
        n_q        <= req_block_i ? CW'(BLOCK_WORDS) : CW'(1);
        xfer_cnt_q <= '0;
        fill_cnt_q <= '0;
      end else begin
        if (issue || wr_drain) xfer_cnt_q <= xfer_cnt_q + CW'(1);
        if (r_push || w_push)  fill_cnt_q <= fill_cnt_q + CW'(1);
      end
    end
  end

  // Read buffer pointers/occupancy
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_wp_q  <= '0;
      r_rp_q  <= '0;
      r_cnt_q <= '0;
    end else begin
      if (r_push) r_wp_q <= r_wp_q + PW'(1);
      if (r_pop)  r_rp_q <= r_rp_q + PW'(1);
      r_cnt_q <= r_cnt_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (r_push) rmem[r_wp_q] <= mem_data_i;
  end

  // Write buffer pointers/occupancy
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      w_wp_q  <= '0;
      w_rp_q  <= '0;
      w_cnt_q <= '0;
    end else begin
      if (w_push) w_wp_q <= w_wp_q + PW'(1);
      if (w_pop)  w_rp_q <= w_rp_q + PW'(1);
      w_cnt_q <= w_cnt_q + FW'(w_push) - FW'(w_pop);
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_push) wmem[w_wp_q] <= data_i;
  end

`ifdef RESP_PERF_CNT_EN
  logic [31:0] cnt_rd_q, cnt_wr_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_rd_q <= '0;
      cnt_wr_q <= '0;
    end else begin
      if ((state_q == RD_DRAIN) && (state_d == IDLE)) cnt_rd_q <= cnt_rd_q + 32'd1;
      if ((state_q == WR) && (state_d == IDLE))       cnt_wr_q <= cnt_wr_q + 32'd1;
    end
  end

  assign cnt_rd_o = cnt_rd_q;
  assign cnt_wr_o = cnt_wr_q;
`else
  assign cnt_rd_o = '0;
  assign cnt_wr_o = '0;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder with a behavioural synchronous backing memory.
module tb_cache_mem_responder;

  localparam int unsigned AW    = 12;
  localparam int unsigned BLK   = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MEMW  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          req_i, req_block_i, rw_i, write_i, read_i;
  logic [AW-1:0] add_i;
  logic [31:0]   data_i;
  logic          ready_req_o, ready_write_o, ready_read_o;
  logic [31:0]   data_o;
  logic [AW-1:0] mem_add_o;
  logic          mem_wren_o;
  logic [31:0]   mem_data_o;
  logic [31:0]   mem_rd;
  logic [31:0]   cnt_rd_o, cnt_wr_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_rd   = 0;
  int          exp_wr   = 0;
  logic [31:0] sb [$];
  logic [31:0] ref_mem [MEMW];
  bit          wvalid  [MEMW];
  logic [31:0] wmem    [MEMW];

  cache_mem_responder #(.BW_ADDR(AW), .BLOCK_WORDS(BLK), .FIFO_DEPTH(DEPTH)) dut (
    .clock_i(clk), .reset_i(reset_i), .req_i(req_i), .req_block_i(req_block_i),
    .rw_i(rw_i), .add_i(add_i), .write_i(write_i), .data_i(data_i), .read_i(read_i),
    .ready_req_o(ready_req_o), .ready_write_o(ready_write_o), .ready_read_o(ready_read_o),
    .data_o(data_o), .mem_add_o(mem_add_o), .mem_wren_o(mem_wren_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_rd), .cnt_rd_o(cnt_rd_o), .cnt_wr_o(cnt_wr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return 32'h5A5A0000 ^ 32'(a * 40503);
  endfunction

  function automatic logic [31:0] mem_word(int a);
    return wvalid[a] ? wmem[a] : pat(a);
  endfunction

  // Backing memory: data valid one cycle after the address
  always @(posedge clk) begin
    if (mem_wren_o) begin
      wmem[mem_add_o]   <= mem_data_o;
      wvalid[mem_add_o] <= 1'b1;
    end
    mem_rd <= mem_word(int'(mem_add_o));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every accepted pop is compared against the oldest expected word
  always @(negedge clk) begin
    if (!reset_i && read_i && ready_read_o) begin
      if (sb.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
      else                check_eq("rd_data", data_o, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_req();
    int t = 0;
    while (!ready_req_o && t < 200) begin
      tick();
      t++;
    end
    check_eq("req_ready_timeout", 32'(ready_req_o), 32'd1);
  endtask

  task automatic send_req(input bit blk, input bit rw, input logic [AW-1:0] a);
    logic [AW-1:0] base, ad;
    int n;
    wait_ready_req();
    req_i = 1'b1; req_block_i = blk; rw_i = rw; add_i = a;
    if (!rw) begin
      base = blk ? (a & ~AW'(BLK - 1)) : a;
      n    = blk ? BLK : 1;
      for (int i = 0; i < n; i++) begin
        ad = base + AW'(i);
        sb.push_back(ref_mem[ad]);
      end
      exp_rd++;
    end else begin
      exp_wr++;
    end
    tick();
    req_i = 1'b0; req_block_i = 1'b0; rw_i = 1'b0; add_i = '0;
  endtask

  task automatic pop_words(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!ready_read_o && t < 100) begin
        tick();
        t++;
      end
      check_eq("rd_ready_timeout", 32'(ready_read_o), 32'd1);
      read_i = 1'b1;
      tick();
      read_i = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(MEMW); i++) ref_mem[i] = pat(i);
    reset_i = 1'b1; req_i = 1'b0; req_block_i = 1'b0; rw_i = 1'b0; add_i = '0;
    write_i = 1'b0; data_i = '0; read_i = 1'b0;
    tick(); tick();

    check_eq("rst_ready_req", 32'(ready_req_o), 32'd1);
    check_eq("rst_ready_read", 32'(ready_read_o), 32'd0);
    check_eq("rst_ready_write", 32'(ready_write_o), 32'd0);
    check_eq("rst_data_o", data_o, 32'd0);
    check_eq("rst_mem_add", 32'(mem_add_o), 32'd0);
    check_eq("rst_mem_wren", 32'(mem_wren_o), 32'd0);
    check_eq("rst_mem_data", mem_data_o, 32'd0);
    check_eq("rst_cnt_rd", cnt_rd_o, 32'd0);
    check_eq("rst_cnt_wr", cnt_wr_o, 32'd0);
    reset_i = 1'b0;
    tick();

    // Single read and its two-edge latency
    send_req(1'b0, 1'b0, AW'(12'h040));
    check_eq("t1_first_addr", 32'(mem_add_o), 32'h040);
    check_eq("t1_lat_e0", 32'(ready_read_o), 32'd0);
    tick();
    check_eq("t1_lat_e1", 32'(ready_read_o), 32'd0);
    tick();
    check_eq("t1_lat_e2", 32'(ready_read_o), 32'd1);
    check_eq("t1_head", data_o, 32'hDEADBEEF);
    pop_words(1);
    check_eq("t1_idle", 32'(ready_req_o), 32'd1);

    // Block read stalls with a full read buffer
    send_req(1'b1, 1'b0, AW'(12'h123));
    check_eq("t2_first_addr", 32'(mem_add_o), 32'h120);
    repeat (20) tick();
    check_eq("t2_stall_ready_read", 32'(ready_read_o), 32'd1);
    check_eq("t2_stall_busy", 32'(ready_req_o), 32'd0);
    check_eq("t2_stall_no_issue", 32'(mem_add_o), 32'd0);
    pop_words(BLK);
    wait_ready_req();

    // write_i while idle must not be absorbed
    write_i = 1'b1; data_i = 32'hBAD0BAD0;
    check_eq("t4_idle_no_wready", 32'(ready_write_o), 32'd0);
    tick();
    write_i = 1'b0;

    // Block write with gaps
    send_req(1'b1, 1'b1, AW'(12'h200));
    for (int i = 0; i < int'(BLK); i++) begin
      int t = 0;
      while (!ready_write_o && t < 100) begin
        tick();
        t++;
      end
      check_eq("t3_wready_timeout", 32'(ready_write_o), 32'd1);
      write_i = 1'b1;
      data_i  = 32'(i + 1);
      ref_mem[12'h200 + i] = 32'(i + 1);
      tick();
      write_i = 1'b0;
      if (i % 3 == 1) tick();
    end
    check_eq("t3_wr_closed", 32'(ready_write_o), 32'd0);
    wait_ready_req();
    for (int i = 0; i < int'(BLK); i++) check_eq("t3_mem", mem_word(12'h200 + i), 32'(i + 1));
    check_eq("t3_no_overrun", mem_word(12'h210), pat(12'h210));
    send_req(1'b1, 1'b0, AW'(12'h205));
    pop_words(BLK);

    // Ignored req during fetch and read_i on an empty buffer
    send_req(1'b1, 1'b0, AW'(12'h300));
    req_i = 1'b1; rw_i = 1'b1; add_i = '0; read_i = 1'b1;
    tick();
    check_eq("t4_addr_kept", 32'(mem_add_o), 32'h301);
    tick();
    req_i = 1'b0; rw_i = 1'b0; read_i = 1'b0;
    check_eq("t4_no_pop_empty", 32'(ready_read_o), 32'd1);
    check_eq("t4_head", data_o, ref_mem[12'h300]);
    pop_words(BLK);
    wait_ready_req();

    // Top-of-space addresses
    send_req(1'b0, 1'b0, AW'(12'hFFF));
    check_eq("t5_top_addr", 32'(mem_add_o), 32'hFFF);
    pop_words(1);
    send_req(1'b1, 1'b0, AW'(12'hFF5));
    check_eq("t5_last_block", 32'(mem_add_o), 32'hFF0);
    pop_words(BLK);
    wait_ready_req();

`ifdef RESP_PERF_CNT_EN
    check_eq("cnt_rd", cnt_rd_o, 32'(exp_rd));
    check_eq("cnt_wr", cnt_wr_o, 32'(exp_wr));
`else
    check_eq("cnt_rd_tied", cnt_rd_o, 32'd0);
    check_eq("cnt_wr_tied", cnt_wr_o, 32'd0);
`endif

    // Reset in the middle of a block read with 5 words buffered
    send_req(1'b1, 1'b0, AW'(12'h080));
    repeat (6) tick();
    check_eq("t6_buffered", 32'(ready_read_o), 32'd1);
    reset_i = 1'b1;
    #1;
    check_eq("t6_rst_ready_read", 32'(ready_read_o), 32'd0);
    check_eq("t6_rst_ready_req", 32'(ready_req_o), 32'd1);
    check_eq("t6_rst_cnt_rd", cnt_rd_o, 32'd0);
    sb.delete();
    exp_rd = 0;
    tick();
    reset_i = 1'b0;
    tick();
    send_req(1'b0, 1'b0, AW'(12'h0A0));
    pop_words(1);
    wait_ready_req();

    check_eq("sb_leftover", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
